// File: rtl/le_input_interconnect.sv
// Stateless input crossbar for a four-LE cluster: every LE input pin picks one LE output
// (or nothing) from a 3-bit select, and each LE output reports which input indices it drives.
module le_input_interconnect #(
    parameter int LE_INPUTS = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic [2:0]           config_data [LE_INPUTS][4],
    input  logic                 leout0A,
    input  logic                 leout0B,
    input  logic                 leout1A,
    input  logic                 leout1B,
    output logic [LE_INPUTS-1:0] lein0A,
    output logic [LE_INPUTS-1:0] lein0B,
    output logic [LE_INPUTS-1:0] lein1A,
    output logic [LE_INPUTS-1:0] lein1B,
    output logic [LE_INPUTS-1:0] drvLE0A,
    output logic [LE_INPUTS-1:0] drvLE0B,
    output logic [LE_INPUTS-1:0] drvLE1A,
    output logic [LE_INPUTS-1:0] drvLE1B
);

    logic [3:0]           le_out;
    logic [LE_INPUTS-1:0] lein [4];
    logic [LE_INPUTS-1:0] drv  [4];

    // clk, nrst and en are kept on the port list for tile compatibility but never affect routing.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, nrst, en};

    assign le_out = {leout1B, leout1A, leout0B, leout0A};

    // Selects 4..7 (bit 2 set) leave the pin at 0; an unknown select only affects its own pin.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            lein[n] = '0;
            drv[n]  = '0;
        end
        for (int j = 0; j < LE_INPUTS; j++) begin
            for (int n = 0; n < 4; n++) begin
                if (config_data[j][n][2] == 1'b0) begin
                    lein[n][j] = le_out[config_data[j][n][1:0]];
                end
                for (int s = 0; s < 4; s++) begin
                    if (config_data[j][n] == 3'(s)) begin
                        drv[s][j] = 1'b1;
                    end
                end
            end
        end
    end

    assign lein0A  = lein[0];
    assign lein0B  = lein[1];
    assign lein1A  = lein[2];
    assign lein1B  = lein[3];
    assign drvLE0A = drv[0];
    assign drvLE0B = drv[1];
    assign drvLE1A = drv[2];
    assign drvLE1B = drv[3];

endmodule

// File: tb/tb_le_input_interconnect.sv
// Self-checking bench for le_input_interconnect: directed routing scenarios plus randomized
// configurations compared against a select-table reference model.
module tb_le_input_interconnect;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [2:0] cfg [4][4];
    logic [3:0] lo;
    logic [3:0] lein0A, lein0B, lein1A, lein1B;
    logic [3:0] drvLE0A, drvLE0B, drvLE1A, drvLE1B;
    logic [31:0] observed;

    int checks;
    int failures;

    le_input_interconnect #(.LE_INPUTS(4)) dut (
        .clk(clk),
        .nrst(nrst),
        .en(en),
        .config_data(cfg),
        .leout0A(lo[0]),
        .leout0B(lo[1]),
        .leout1A(lo[2]),
        .leout1B(lo[3]),
        .lein0A(lein0A),
        .lein0B(lein0B),
        .lein1A(lein1A),
        .lein1B(lein1B),
        .drvLE0A(drvLE0A),
        .drvLE0B(drvLE0B),
        .drvLE1A(drvLE1A),
        .drvLE1B(drvLE1B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: [15:0] = lein {1B,1A,0B,0A}, [31:16] = drvLE {1B,1A,0B,0A}.
    assign observed = {drvLE1B, drvLE1A, drvLE0B, drvLE0A, lein1B, lein1A, lein0B, lein0A};

    // Reference: a pin reads the LE output numbered by its select, 0 when select >= 4.
    function automatic logic [31:0] model(input logic [3:0] outs);
        logic [3:0] pin [4];
        logic [3:0] drv [4];
        for (int n = 0; n < 4; n++) begin
            pin[n] = 4'h0;
            drv[n] = 4'h0;
        end
        for (int j = 0; j < 4; j++) begin
            for (int n = 0; n < 4; n++) begin
                if (cfg[j][n] < 3'd4) begin
                    pin[n][j] = outs[cfg[j][n][1:0]];
                    drv[cfg[j][n][1:0]][j] = 1'b1;
                end
            end
        end
        return {drv[3], drv[2], drv[1], drv[0], pin[3], pin[2], pin[1], pin[0]};
    endfunction

    task automatic set_all(input logic [2:0] v);
        for (int j = 0; j < 4; j++)
            for (int n = 0; n < 4; n++)
                cfg[j][n] = v;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0;
        set_all(3'd7);
        lo = 4'hF;
        #1;
        checks++;
        if (observed !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_all_off got=%h want=%h", observed, 32'h0);
        end
        nrst = 1'b1;
    endtask

    task automatic test_all_off();
        set_all(3'd7);
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            lo = 4'(v);
            #1;
            checks++;
            if (observed !== 32'h0) begin
                failures++;
                $display("[TB] FAIL all_off lo=%h got=%h want=%h", lo, observed, 32'h0);
            end
        end
    endtask

    task automatic test_single_route();
        logic [31:0] exp;
        set_all(3'd7);
        cfg[0][0] = 3'd1;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            lo = 4'(v);
            #1;
            exp = 32'h0010_0000 | {31'h0, lo[1]};
            checks++;
            if (observed !== exp) begin
                failures++;
                $display("[TB] FAIL single_route lo=%h got=%h want=%h", lo, observed, exp);
            end
        end
    endtask

    task automatic set_cross();
        set_all(3'd7);
        cfg[0][0] = 3'd1;
        cfg[0][1] = 3'd2;
        cfg[0][2] = 3'd3;
        cfg[0][3] = 3'd0;
    endtask

    task automatic test_cross(input bit wiggle_ctrl);
        logic [31:0] exp;
        set_cross();
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            lo = 4'(v);
            if (wiggle_ctrl) begin
                en   = 1'b0;
                nrst = v[0];
            end
            #1;
            exp = 32'h1111_0000 | {19'h0, lo[0], 3'h0, lo[3], 3'h0, lo[2], 3'h0, lo[1]};
            checks++;
            if (observed !== exp) begin
                failures++;
                $display("[TB] FAIL cross ctrl=%0d lo=%h got=%h want=%h", wiggle_ctrl, lo, observed, exp);
            end
        end
        nrst = 1'b1;
        en   = 1'b1;
    endtask

    task automatic test_feedback();
        for (int j = 0; j < 4; j++)
            for (int n = 0; n < 4; n++)
                cfg[j][n] = 3'(n);
        @(negedge clk);
        lo = 4'b1010;
        #1;
        checks++;
        if (observed !== 32'hFFFF_F0F0) begin
            failures++;
            $display("[TB] FAIL feedback got=%h want=%h", observed, 32'hFFFF_F0F0);
        end
    endtask

    task automatic test_fanout();
        logic [31:0] exp;
        set_all(3'd2);
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            lo = {$urandom_range(0, 1) == 1, v[0], $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1};
            #1;
            exp = 32'h0F00_0000 | (lo[2] ? 32'h0000_FFFF : 32'h0);
            checks++;
            if (observed !== exp) begin
                failures++;
                $display("[TB] FAIL fanout lo=%h got=%h want=%h", lo, observed, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                for (int n = 0; n < 4; n++)
                    cfg[j][n] = 3'($urandom_range(0, 7));
            lo = 4'($urandom);
            #1;
            exp = model(lo);
            checks++;
            if (observed !== exp) begin
                failures++;
                $display("[TB] FAIL random it=%0d lo=%h got=%h want=%h", it, lo, observed, exp);
            end
        end
    endtask

    task automatic test_x_isolation();
        logic [31:0] exp;
        logic [31:0] mask;
        mask = ~32'h1111_0001;
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                for (int n = 0; n < 4; n++)
                    cfg[j][n] = 3'($urandom_range(0, 7));
            cfg[0][0] = 3'bxxx;
            lo = 4'($urandom);
            #1;
            exp = model(lo) & mask;
            checks++;
            if ((observed & mask) !== exp) begin
                failures++;
                $display("[TB] FAIL x_isolation lo=%h got=%h want=%h", lo, observed & mask, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b1;
        en       = 1'b1;
        lo       = 4'h0;
        set_all(3'd7);
        test_reset();
        test_all_off();
        test_single_route();
        test_cross(1'b0);
        test_feedback();
        test_fanout();
        test_cross(1'b1);
        test_random();
        test_x_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
